// File: rtl/miller_mod.sv
// Miller-M subcarrier encoder: serialises framed data bits into a backscatter level, appending a trailing dummy 1.
// Latency: first chip appears on out_data one cycle after the accepting edge; bits follow back-to-back.
// Backpressure: in_ready rises only in the final cycle of a non-last bit; a missing bit there is an underrun.
module miller_mod #(
    parameter int CHIP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_enable,
    input  logic [1:0] m_sel,
    input  logic       in_valid,
    input  logic       in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_data,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_err
);
    typedef enum logic [1:0] {S_IDLE, S_BIT, S_DUMMY} state_t;

    localparam logic [7:0] CHIP_LAST = 8'(CHIP_CYC - 1);

    state_t     state_q;
    logic [7:0] chip_q;
    logic [3:0] k_q;
    logic [1:0] m_q;
    logic       level_q;
    logic       prev_bit_q;
    logic       cur_bit_q;
    logic       cur_last_q;
    logic       out_data_q;
    logic       out_busy_q;
    logic       out_done_q;
    logic       out_err_q;

    logic [3:0] k_mid;
    logic [3:0] k_max;
    logic [3:0] k_nx;
    logic       chip_end;
    logic       bit_end;
    logic       mid_lvl_d;
    logic       next_lvl_d;
    logic       start_lvl_d;

    // m_q holds log2(M)-1; the m_sel=11 alias is folded into M=8 when latched.
    always_comb begin
        case (m_q)
            2'd0:    begin k_mid = 4'd2; k_max = 4'd3;  end
            2'd1:    begin k_mid = 4'd4; k_max = 4'd7;  end
            default: begin k_mid = 4'd8; k_max = 4'd15; end
        endcase
    end

    assign k_nx     = k_q + 4'd1;
    assign chip_end = (chip_q == CHIP_LAST);
    assign bit_end  = chip_end && (k_q == k_max);

    // Next chip inside the same bit: a 1 flips the level at k=M.
    assign mid_lvl_d   = level_q ^ (cur_bit_q & (k_nx == k_mid));
    // First chip of a following bit: the finished bit becomes prev_bit, so a 0-0 boundary flips.
    assign next_lvl_d  = level_q ^ (~cur_bit_q & ~in_data);
    assign start_lvl_d = level_q ^ (~prev_bit_q & ~in_data);

    assign in_ready = in_enable & ~rst &
                      ((state_q == S_IDLE) | ((state_q == S_BIT) & bit_end & ~cur_last_q));

    always_ff @(posedge clk) begin
        if (rst || !in_enable) begin
            state_q    <= S_IDLE;
            chip_q     <= '0;
            k_q        <= '0;
            m_q        <= '0;
            level_q    <= 1'b0;
            prev_bit_q <= 1'b1;
            cur_bit_q  <= 1'b0;
            cur_last_q <= 1'b0;
            out_data_q <= 1'b0;
            out_busy_q <= 1'b0;
            out_done_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            out_done_q <= 1'b0;
            out_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q    <= S_BIT;
                        m_q        <= (m_sel == 2'b11) ? 2'd2 : m_sel;
                        chip_q     <= '0;
                        k_q        <= '0;
                        cur_bit_q  <= in_data;
                        cur_last_q <= in_last;
                        level_q    <= start_lvl_d;
                        out_data_q <= start_lvl_d;
                        out_busy_q <= 1'b1;
                    end
                end
                default: begin
                    if (!chip_end) begin
                        chip_q <= chip_q + 8'd1;
                    end else begin
                        chip_q <= '0;
                        if (!bit_end) begin
                            k_q        <= k_nx;
                            level_q    <= mid_lvl_d;
                            out_data_q <= mid_lvl_d ^ k_nx[0];
                        end else begin
                            k_q        <= '0;
                            prev_bit_q <= cur_bit_q;
                            if ((state_q == S_BIT) && cur_last_q) begin
                                // Dummy 1 never flips at its start.
                                state_q    <= S_DUMMY;
                                cur_bit_q  <= 1'b1;
                                out_data_q <= level_q;
                            end else if ((state_q == S_BIT) && in_valid && in_ready) begin
                                cur_bit_q  <= in_data;
                                cur_last_q <= in_last;
                                level_q    <= next_lvl_d;
                                out_data_q <= next_lvl_d;
                            end else begin
                                state_q    <= S_IDLE;
                                level_q    <= 1'b0;
                                prev_bit_q <= 1'b1;
                                out_data_q <= 1'b0;
                                out_busy_q <= 1'b0;
                                if (state_q == S_DUMMY) begin
                                    out_done_q <= 1'b1;
                                end else begin
                                    out_err_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign out_data = out_data_q;
    assign out_busy = out_busy_q;
    assign out_done = out_done_q;
    assign out_err  = out_err_q;

endmodule
